// File: rtl/press_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : press_decoder
//  Description : Classifies conditioned button gestures into short, long and
//                double presses, each emitted as a registered 1-cycle pulse.
//                Define PRESS_DECODER_REPEAT_EN to enable auto-repeat pulses
//                while a long press is held.
//  Revision    : 1.0 - initial release
// ============================================================================
module press_decoder #(
    parameter int CNT_W    = 16,
    parameter int LONG_T   = 8,
    parameter int DOUBLE_T = 6,
    parameter int REPEAT_T = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic conditioned,
    input  logic rising,
    input  logic falling,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_press,
    output logic busy
);

    localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_T - 1);
    localparam logic [CNT_W-1:0] C_DOUBLE_LAST = CNT_W'(DOUBLE_T - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_T - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_LONG   = 3'd2,
        S_WAIT2  = 3'd3,
        S_PRESS2 = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;

    // Simultaneous rising and falling is illegal: both are masked off.
    assign w_rise    = rising & ~falling;
    assign w_fall    = falling & ~rising;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

`ifdef PRESS_DECODER_REPEAT_EN
    logic r_repeat;
    assign repeat_press = r_repeat;
`else
    logic w_unused_repeat;
    assign w_unused_repeat = ^C_REPEAT_LAST;
    assign repeat_press    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
`ifdef PRESS_DECODER_REPEAT_EN
            r_repeat <= 1'b0;
`endif
        end else begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
`ifdef PRESS_DECODER_REPEAT_EN
            r_repeat <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state <= S_PRESS1;
                    end
                end
                S_PRESS1: begin
                    if (w_fall) begin
                        r_state <= S_WAIT2;
                        r_cnt   <= '0;
                    end else if (!conditioned) begin
                        // Level dropped without a falling pulse: lost edge.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_LONG_LAST) begin
                        r_state <= S_LONG;
                        r_long  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_LONG: begin
                    if (w_fall || !conditioned) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
`ifdef PRESS_DECODER_REPEAT_EN
                    else if (r_cnt == C_REPEAT_LAST) begin
                        r_repeat <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                S_WAIT2: begin
                    if (w_rise) begin
                        r_state <= S_PRESS2;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_DOUBLE_LAST) begin
                        r_state <= S_IDLE;
                        r_short <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_PRESS2: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state  <= S_IDLE;
                        r_double <= 1'b1;
                    end else if (!conditioned) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_press = r_double;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire
